// File: rtl/display_scan_controller.sv
// display_scan_controller
// Drives a multiplexed common-anode seven-segment display. Each rising edge
// of Refresh advances the scan by one digit, and a blanking gap separates
// consecutive digits to suppress ghosting. New digit data arrives through a
// req/ack handshake into a shadow buffer. The shadow buffer is copied into the
// active buffer only at frame boundaries, or while the scan is idle, so a
// frame never shows a mix of old and new data.

module display_scan_controller #(
  parameter int NumDigits   = 4,
  parameter int BlankCycles = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Refresh,
  input  logic                     En,
  input  logic                     LoadReq,
  input  logic [4*NumDigits-1:0]   LoadData,
  input  logic [NumDigits-1:0]     LoadMask,
  output logic                     LoadAck,
  output logic [NumDigits-1:0]     Anode,
  output logic [6:0]               Seg,
  output logic                     FrameStart
);

  localparam int IdxW = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam int CntW = (BlankCycles > 1) ? $clog2(BlankCycles) : 1;
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumDigits - 1);
  localparam logic [CntW-1:0] LastBlank = CntW'(BlankCycles - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scanState_t;

  scanState_t state, stateNext;
  logic [IdxW-1:0] digitIdx, digitIdxNext;
  logic [CntW-1:0] blankCnt, blankCntNext;

  logic refreshQ;
  logic tick;
  logic frameStart;
  logic transfer;
  logic capture;

  logic [4*NumDigits-1:0] shadowData, activeData;
  logic [NumDigits-1:0]   shadowMask, activeMask;
  logic                   pending;

  logic [3:0]           curNibble;
  logic                 lit;
  logic [NumDigits-1:0] anodeNext;
  logic [6:0]           segNext;

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hexToSeg(input logic [3:0] hex);
    case (hex)
      4'h0: hexToSeg = 7'h40;
      4'h1: hexToSeg = 7'h79;
      4'h2: hexToSeg = 7'h24;
      4'h3: hexToSeg = 7'h30;
      4'h4: hexToSeg = 7'h19;
      4'h5: hexToSeg = 7'h12;
      4'h6: hexToSeg = 7'h02;
      4'h7: hexToSeg = 7'h78;
      4'h8: hexToSeg = 7'h00;
      4'h9: hexToSeg = 7'h10;
      4'hA: hexToSeg = 7'h08;
      4'hB: hexToSeg = 7'h03;
      4'hC: hexToSeg = 7'h46;
      4'hD: hexToSeg = 7'h21;
      4'hE: hexToSeg = 7'h06;
      default: hexToSeg = 7'h0E;
    endcase
  endfunction

  // Keep sampling Refresh through reset so the first cycle after reset release cannot see a false edge
  always_ff @(posedge Clk) begin
    refreshQ <= Refresh;
  end

  assign tick    = Refresh & ~refreshQ;
  assign capture = LoadReq & ~pending & ~LoadAck;

  // State register for the scan sequencer
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      digitIdx <= '0;
      blankCnt <= '0;
    end else begin
      state    <= stateNext;
      digitIdx <= digitIdxNext;
      blankCnt <= blankCntNext;
    end
  end

  // Next-state logic: advance on ticks, time the blanking gap, and flag frame starts and buffer swaps
  always_comb begin
    stateNext    = state;
    digitIdxNext = digitIdx;
    blankCntNext = blankCnt;
    frameStart   = 1'b0;
    transfer     = 1'b0;
    case (state)
      IDLE: begin
        transfer = pending;
        if (tick) begin
          stateNext    = BLANK;
          digitIdxNext = '0;
          blankCntNext = '0;
          frameStart   = 1'b1;
        end
      end
      BLANK: begin
        if (blankCnt == LastBlank) begin
          stateNext = SHOW;
        end else begin
          blankCntNext = blankCnt + 1'b1;
        end
      end
      SHOW: begin
        if (tick) begin
          stateNext    = BLANK;
          blankCntNext = '0;
          if (digitIdx == LastIdx) begin
            digitIdxNext = '0;
            frameStart   = 1'b1;
            transfer     = pending;
          end else begin
            digitIdxNext = digitIdx + 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    if (!En) begin
      stateNext    = IDLE;
      digitIdxNext = '0;
      frameStart   = 1'b0;
      transfer     = transfer && (state == IDLE);
    end
  end

  // Load handshake and double buffer: capture into the shadow, swap into the active buffer at frame boundaries
  always_ff @(posedge Clk) begin
    if (Rst) begin
      shadowData <= '0;
      shadowMask <= '0;
      activeData <= '0;
      activeMask <= '0;
      pending    <= 1'b0;
      LoadAck    <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      LoadAck    <= capture;
      FrameStart <= frameStart;
      if (capture) begin
        shadowData <= LoadData;
        shadowMask <= LoadMask;
        pending    <= 1'b1;
      end else if (transfer) begin
        activeData <= shadowData;
        activeMask <= shadowMask;
        pending    <= 1'b0;
      end
    end
  end

  // Select the current digit and decide whether it is lit
  always_comb begin
    curNibble = activeData[{digitIdx, 2'b00} +: 4];
    lit       = (state == SHOW) && activeMask[digitIdx];
    segNext   = lit ? hexToSeg(curNibble) : 7'h7F;
    anodeNext = '1;
    for (int i = 0; i < NumDigits; i++) begin
      anodeNext[i] = !(lit && (digitIdx == IdxW'(i)));
    end
  end

  // Register the display drive so the pins stay glitch-free
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Anode <= '1;
      Seg   <= 7'h7F;
    end else begin
      Anode <= anodeNext;
      Seg   <= segNext;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
// Self-checking bench for display_scan_controller. A behavioural model that
// tracks the scan position predicts the outputs for every clock cycle and
// queues them. A monitor process pops one prediction per cycle and compares
// it with the DUT outputs.

module tb_display_scan_controller;

  localparam int N = 4;
  localparam int B = 2;

  logic           Clk = 1'b0;
  logic           Rst;
  logic           Refresh;
  logic           En;
  logic           LoadReq;
  logic [4*N-1:0] LoadData;
  logic [N-1:0]   LoadMask;
  logic           LoadAck;
  logic [N-1:0]   Anode;
  logic [6:0]     Seg;
  logic           FrameStart;

  display_scan_controller #(.NumDigits(N), .BlankCycles(B)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Refresh    (Refresh),
    .En         (En),
    .LoadReq    (LoadReq),
    .LoadData   (LoadData),
    .LoadMask   (LoadMask),
    .LoadAck    (LoadAck),
    .Anode      (Anode),
    .Seg        (Seg),
    .FrameStart (FrameStart)
  );

  typedef struct packed {
    logic [N-1:0] anode;
    logic [6:0]   seg;
    logic         ack;
    logic         fs;
  } expect_t;

  expect_t expQ[$];
  int vectors     = 0;
  int miscompares = 0;

  // Reference model: scan mode 0 = dark, 1 = gap between digits, 2 = digit lit
  int             mMode;
  int             mDigit;
  int             mGapLeft;
  bit             mRefPrev;
  bit             mPending;
  logic [4*N-1:0] mShadowData, mActiveData;
  logic [N-1:0]   mShadowMask, mActiveMask;
  expect_t        mOut;
  logic [6:0]     segTable [16];

  // Requester and refresh waveform state
  bit             reqActive;
  logic [4*N-1:0] reqData;
  logic [N-1:0]   reqMask;
  bit             autoLoad;
  int             refPeriod;
  int             refCnt;

  always #5 Clk = ~Clk;

  // Advance the model by one clock edge using the inputs now being driven
  task automatic modelStep();
    bit      tick;
    bit      oldPending;
    bit      oldAck;
    bit      doXfer;
    int      oldMode;
    expect_t nxt;
    tick     = Refresh && !mRefPrev;
    mRefPrev = Refresh;
    if (Rst) begin
      mMode       = 0;
      mDigit      = 0;
      mGapLeft    = 0;
      mPending    = 0;
      mShadowData = '0;
      mShadowMask = '0;
      mActiveData = '0;
      mActiveMask = '0;
      mOut.anode  = '1;
      mOut.seg    = 7'h7F;
      mOut.ack    = 1'b0;
      mOut.fs     = 1'b0;
      return;
    end
    nxt.anode = '1;
    nxt.seg   = 7'h7F;
    nxt.ack   = 1'b0;
    nxt.fs    = 1'b0;
    if (mMode == 2 && mActiveMask[mDigit]) begin
      nxt.anode[mDigit] = 1'b0;
      nxt.seg           = segTable[mActiveData[4*mDigit +: 4]];
    end
    oldMode    = mMode;
    oldPending = mPending;
    oldAck     = mOut.ack;
    doXfer     = 0;
    if (!En) begin
      mMode  = 0;
      mDigit = 0;
      doXfer = (oldMode == 0) && oldPending;
    end else if (mMode == 0) begin
      doXfer = oldPending;
      if (tick) begin
        mMode    = 1;
        mGapLeft = B;
        mDigit   = 0;
        nxt.fs   = 1'b1;
      end
    end else if (mMode == 1) begin
      mGapLeft--;
      if (mGapLeft == 0) mMode = 2;
    end else if (tick) begin
      mMode    = 1;
      mGapLeft = B;
      mDigit   = (mDigit + 1) % N;
      if (mDigit == 0) begin
        nxt.fs = 1'b1;
        doXfer = oldPending;
      end
    end
    if (LoadReq && !oldPending && !oldAck) begin
      mShadowData = LoadData;
      mShadowMask = LoadMask;
      mPending    = 1;
      nxt.ack     = 1'b1;
    end
    if (doXfer) begin
      mActiveData = mShadowData;
      mActiveMask = mShadowMask;
      mPending    = 0;
    end
    mOut = nxt;
  endtask

  // Drive one cycle of inputs, predict the result, and wait for the next drive point
  task automatic applyStimulus(input bit rst, input bit en);
    if (mOut.ack) reqActive = 0;
    if (autoLoad && !reqActive && $urandom_range(0, 7) == 0) begin
      reqActive = 1;
      reqData   = 16'($urandom);
      reqMask   = 4'($urandom);
    end
    Rst      = rst;
    En       = en;
    Refresh  = ((refCnt % refPeriod) >= (refPeriod / 2));
    refCnt++;
    LoadReq  = reqActive;
    LoadData = reqData;
    LoadMask = reqMask;
    modelStep();
    expQ.push_back(mOut);
    @(negedge Clk);
  endtask

  task automatic runCycles(input int n, input bit rst, input bit en);
    for (int i = 0; i < n; i++) applyStimulus(rst, en);
  endtask

  // Wait (bounded) for the requester to go idle, then post a new load request
  task automatic startLoad(input logic [4*N-1:0] data, input logic [N-1:0] mask, input bit en);
    int guard;
    guard = 0;
    while (reqActive && guard < 200) begin
      applyStimulus(0, en);
      guard++;
    end
    reqActive = 1;
    reqData   = data;
    reqMask   = mask;
  endtask

  task automatic checkOutput(input expect_t e);
    vectors++;
    if (Anode !== e.anode || Seg !== e.seg || LoadAck !== e.ack || FrameStart !== e.fs) begin
      miscompares++;
      $display("[TB] FAIL outputs @%0t: got Anode=%b Seg=%h LoadAck=%b FrameStart=%b, expected Anode=%b Seg=%h LoadAck=%b FrameStart=%b",
               $time, Anode, Seg, LoadAck, FrameStart, e.anode, e.seg, e.ack, e.fs);
    end
  endtask

  // Monitor: one prediction is consumed per clock, sampled just after the edge
  initial begin
    expect_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int guard;
    segTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    mMode = 0; mDigit = 0; mGapLeft = 0; mRefPrev = 0; mPending = 0;
    mShadowData = '0; mShadowMask = '0; mActiveData = '0; mActiveMask = '0;
    mOut = '0;
    reqActive = 0; reqData = '0; reqMask = '0; autoLoad = 0;
    refPeriod = 6; refCnt = 0;

    $display("[TB] reset with Refresh running");
    runCycles(3, 1, 0);
    runCycles(3, 0, 0);

    $display("[TB] load 1234 while idle");
    startLoad(16'h1234, 4'hF, 0);
    runCycles(6, 0, 0);

    $display("[TB] scan enabled, refresh period 6");
    runCycles(60, 0, 1);

    $display("[TB] masked digits 1 and 3");
    startLoad(16'h1234, 4'b0101, 1);
    runCycles(60, 0, 1);

    $display("[TB] load ABCD mid-frame followed by a second request");
    startLoad(16'h1234, 4'hF, 1);
    runCycles(40, 0, 1);
    startLoad(16'hABCD, 4'hF, 1);
    startLoad(16'h5678, 4'hF, 1);
    runCycles(80, 0, 1);

    $display("[TB] drop and restore enable");
    guard = 0;
    while (!(mMode == 2 && mDigit == 2) && guard < 100) begin
      applyStimulus(0, 1);
      guard++;
    end
    runCycles(5, 0, 0);
    runCycles(30, 0, 1);

    $display("[TB] reset during a lit digit with a request pending");
    guard = 0;
    while (mMode != 2 && guard < 100) begin
      applyStimulus(0, 1);
      guard++;
    end
    reqActive = 1; reqData = 16'h9E0F; reqMask = 4'hF;
    runCycles(1, 1, 1);
    runCycles(40, 0, 1);

    $display("[TB] randomized traffic");
    autoLoad = 1;
    for (int chunk = 0; chunk < 30; chunk++) begin
      int len;
      bit en;
      refPeriod = $urandom_range(2, 10);
      len = $urandom_range(20, 100);
      en  = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 9) == 0) runCycles($urandom_range(1, 2), 1, en);
      runCycles(len, 0, en);
    end
    autoLoad = 0;

    @(negedge Clk);
    @(negedge Clk);
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard drain: %0d predictions left unchecked, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
